// File: rtl/pzvbus_credit_tx_if.sv
// pzvbus credit transmitter bus bundle: upstream ready/valid side plus downstream pzvbus link.
// Signal names are from the transmitter's point of view.
interface pzvbus_credit_tx_if #(
  parameter int unsigned PAYLOAD_WIDTH = 32
);
  logic                     i_valid;
  logic                     o_ready;
  logic [PAYLOAD_WIDTH-1:0] i_payload;
  logic                     o_valid;
  logic [PAYLOAD_WIDTH-1:0] o_payload;
  logic                     i_credit_return;

  // Transmitter side.
  modport slave (
    input  i_valid,
    input  i_payload,
    input  i_credit_return,
    output o_ready,
    output o_valid,
    output o_payload
  );

  // Environment side: upstream source plus remote receiver.
  modport master (
    output i_valid,
    output i_payload,
    output i_credit_return,
    input  o_ready,
    input  o_valid,
    input  o_payload
  );
endinterface

// File: rtl/pzvbus_credit_tx.sv
// Credit-based pzvbus transmitter: forwards upstream beats only while a credit is held,
// so the remote FIFO of depth CREDITS can never overflow.
module pzvbus_credit_tx #(
  parameter int unsigned CREDITS       = 8,
  parameter int unsigned PAYLOAD_WIDTH = 32,
  parameter bit          CLEAR_DATA    = 1'b0,
  localparam int unsigned CW           = $clog2(CREDITS + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  pzvbus_credit_tx_if.slave        bus,
  output logic [CW-1:0]            o_credit_count,
  output logic                     o_idle,
  output logic                     o_credit_error
);

  localparam logic [CW-1:0] MaxCnt = CW'(CREDITS);

  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
  logic                     err_q, err_d;
  logic                     ready;
  logic                     fire;
  logic                     ret;

  // Ready comes from the counter register only; a return never bypasses into it.
  assign ready = (cnt_q != '0);
  assign fire  = bus.i_valid & ready;
  assign ret   = bus.i_credit_return;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({fire, ret})
      2'b10:   cnt_d = cnt_q - CW'(1);
      2'b01:   cnt_d = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    err_d     = err_q | (ret & ~fire & (cnt_q == MaxCnt));
    valid_d   = fire;
    payload_d = payload_q;
    if (fire) begin
      payload_d = bus.i_payload;
    end else if (CLEAR_DATA) begin
      payload_d = '0;
    end
  end

  // Soft clear behaves exactly like reset and discards any concurrent fire/return.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      cnt_q     <= MaxCnt;
      valid_q   <= 1'b0;
      payload_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      payload_q <= payload_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_payload   = payload_q;
  assign o_credit_count  = cnt_q;
  assign o_credit_error  = err_q;
  assign o_idle          = (cnt_q == MaxCnt) & ~valid_q;

endmodule
